// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage.
//   DATA_W    : data/address width of the datapath
//   mem_op_e  : operation codes carried from the controller
//   state_e   : memory stage FSM states
//   ctx_t     : per-operation context latched at the start strobe
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [1:0] {
    MEM_PASS  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    mem_op_e op;
    logic    fault;
  } ctx_t;

  // Reserved encoding behaves as a pass-through.
  function automatic mem_op_e norm_op(input logic [OP_W-1:0] op);
    case (op)
      2'b01:   return MEM_LOAD;
      2'b10:   return MEM_STORE;
      default: return MEM_PASS;
    endcase
  endfunction

  // Word accesses need a 4-byte aligned, non-overflowed address.
  function automatic logic addr_fault(input logic [DATA_W-1:0] addr, input logic ovf);
    return (addr[1:0] != 2'b00) || ovf;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus.
//   master : memory stage (drives dm_req/dm_we/dm_addr/dm_wdata)
//   slave  : data memory  (drives dm_rdata/dm_ack)
interface mem_access_if #(
  parameter int unsigned ADDR_W = 10
);
  import mem_access_pkg::*;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );

endinterface

// File: rtl/mem_access_timer.sv
// Access timeout counter.
//   clock, reset : clock and synchronous active-high reset
//   clear        : forces the count back to zero
//   enable       : counts one per cycle while high
//   expired_c    : combinational, high in the TIMEOUT-th enabled cycle
module mem_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = enable && (count_q == LAST);

endmodule

// File: rtl/mem_access.sv
// Memory stage: turns an ALU sum into a data-memory access (or a
// pass-through), and returns the result to write-back.
//   clock, reset  : clock and synchronous active-high reset
//   enable_mem    : start strobe, honoured only when idle
//   mem_op        : PASS / LOAD / STORE (reserved = PASS)
//   alu_result    : byte address for LOAD/STORE, result for PASS
//   alu_overflow  : overflow of the address add
//   store_data    : STORE write data
//   dm            : data-memory req/ack bus (master side)
//   wb_data       : value for the register file
//   wb_valid      : pulse, wb_data valid (PASS and successful LOAD)
//   mem_done      : pulse, operation finished (including faults)
//   mem_busy      : high while not idle
//   mem_fault     : pulse with mem_done on misalign/overflow/timeout
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_mem,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  input  logic [DATA_W-1:0] store_data,
  mem_access_if.master      dm,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_fault
);

  state_e            state_q, state_d;
  ctx_t              ctx_q, ctx_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              mem_done_q, mem_done_d;
  logic              mem_busy_q, mem_busy_d;
  logic              mem_fault_q, mem_fault_d;
  logic              in_access_c;
  logic              timer_expired_c;

  assign in_access_c = (state_q == ST_ACCESS);

  // Counts cycles spent in ACCESS; held at zero elsewhere.
  mem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (!in_access_c),
    .enable    (in_access_c),
    .expired_c (timer_expired_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    mem_done_d  = 1'b0;
    mem_fault_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_mem) begin
          ctx_d.op    = norm_op(mem_op);
          ctx_d.fault = (ctx_d.op != MEM_PASS) && addr_fault(alu_result, alu_overflow);
          if (ctx_d.op == MEM_PASS) begin
            wb_data_d = alu_result;
            state_d   = ST_RESP;
          end else if (ctx_d.fault) begin
            state_d   = ST_RESP;
          end else begin
            state_d    = ST_ACCESS;
            dm_req_d   = 1'b1;
            dm_we_d    = (ctx_d.op == MEM_STORE);
            dm_addr_d  = alu_result[ADDR_W+1:2];
            dm_wdata_d = store_data;
          end
        end
      end

      ST_ACCESS: begin
        // An ack in the last allowed cycle still completes the access.
        if (dm.dm_ack) begin
          state_d  = ST_RESP;
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          if (ctx_q.op == MEM_LOAD) begin
            wb_data_d = dm.dm_rdata;
          end
        end else if (timer_expired_c) begin
          state_d     = ST_RESP;
          dm_req_d    = 1'b0;
          dm_we_d     = 1'b0;
          ctx_d.fault = 1'b1;
        end
      end

      ST_RESP: begin
        // Completion flags are registered here, so they pulse in the
        // first idle cycle, which is also when a new strobe can be taken.
        state_d     = ST_IDLE;
        mem_done_d  = 1'b1;
        mem_fault_d = ctx_q.fault;
        wb_valid_d  = !ctx_q.fault && (ctx_q.op != MEM_STORE);
      end

      default: begin
        state_d  = ST_IDLE;
        dm_req_d = 1'b0;
        dm_we_d  = 1'b0;
      end
    endcase

    mem_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ctx_q       <= '{op: MEM_PASS, fault: 1'b0};
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      mem_busy_q  <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      wb_data_q   <= wb_data_d;
      wb_valid_q  <= wb_valid_d;
      mem_done_q  <= mem_done_d;
      mem_busy_q  <= mem_busy_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;
  assign wb_data     = wb_data_q;
  assign wb_valid    = wb_valid_q;
  assign mem_done    = mem_done_q;
  assign mem_busy    = mem_busy_q;
  assign mem_fault   = mem_fault_q;

endmodule
